mem_port_arbiter: RTL and testbench

//  Shares the single main-memory port between the CPU instruction-fetch side (I) and the MEM-stage data side (D).

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 73 +++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory-side handshake bundle for mem_port_arbiter
// slave modport: the arbiter (takes I/D requests and memory responses, drives stalls, read data and strobes)
// master modport: the environment (CPU core plus memory model)
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  I_READ;
  logic [ADDR_WIDTH-1:0] I_ADDRESS;
  logic [DATA_WIDTH-1:0] I_READ_DATA;
  logic                  I_BUSYWAIT;
  logic                  D_READ;
  logic                  D_WRITE;
  logic [ADDR_WIDTH-1:0] D_ADDRESS;
  logic [DATA_WIDTH-1:0] D_WRITE_DATA;
  logic [DATA_WIDTH-1:0] D_READ_DATA;
  logic                  D_BUSYWAIT;
  logic                  MEM_READ;
  logic                  MEM_WRITE;
  logic [ADDR_WIDTH-1:0] MEM_ADDRESS;
  logic [DATA_WIDTH-1:0] MEM_WRITE_DATA;
  logic [DATA_WIDTH-1:0] MEM_READ_DATA;
  logic                  MEM_BUSYWAIT;
  logic [1:0]            ARB_STATE;
  modport slave (
    input  I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITE_DATA, MEM_READ_DATA, MEM_BUSYWAIT,
    output I_READ_DATA, I_BUSYWAIT, D_READ_DATA, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS,
           MEM_WRITE_DATA, ARB_STATE
  );
  modport master (
    output I_READ, I_ADDRESS, D_READ, D_WRITE, D_ADDRESS, D_WRITE_DATA, MEM_READ_DATA, MEM_BUSYWAIT,
    input  I_READ_DATA, I_BUSYWAIT, D_READ_DATA, D_BUSYWAIT, MEM_READ, MEM_WRITE, MEM_ADDRESS,
           MEM_WRITE_DATA, ARB_STATE
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and data (D), D priority with starvation guard
// CLK/RESET: clock and synchronous active-high reset
// bus: fetch/data request side, registered memory strobes/address/data, debug ARB_STATE
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               CLK,
  input logic               RESET,
  mem_port_arbiter_if.slave bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, RESP = 2'd3} state_t;
  state_t                r_state, w_next;
  logic                  r_grant;
  logic [CW-1:0]         r_starve;
  logic                  r_mem_read, r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata, r_i_rdata, r_d_rdata;
  logic                  w_i_req, w_d_req, w_pick_i, w_grant_i, w_grant_d, w_done;
  assign w_i_req   = bus.I_READ;
  assign w_d_req   = bus.D_READ | bus.D_WRITE;
  // fetch only beats a pending data request once D has won STARVE_LIMIT times in a row over it
  assign w_pick_i  = w_i_req & (~w_d_req | (r_starve == CW'(STARVE_LIMIT)));
  assign w_grant_i = (r_state == IDLE) & w_pick_i;
  assign w_grant_d = (r_state == IDLE) & ~w_pick_i & w_d_req;
  assign w_done    = ((r_state == BUSY_I) | (r_state == BUSY_D)) & ~bus.MEM_BUSYWAIT;
  always_comb begin
    w_next = r_state;
    w_next = w_grant_i ? BUSY_I : w_grant_d ? BUSY_D : w_done ? RESP : (r_state == RESP) ? IDLE : r_state;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_grant     <= 1'b1;
      r_starve    <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_i | w_grant_d) begin
        r_grant     <= w_grant_d;
        r_mem_addr  <= w_grant_d ? bus.D_ADDRESS : bus.I_ADDRESS;
        r_mem_read  <= w_grant_i | ~bus.D_WRITE;
        r_mem_write <= w_grant_d & bus.D_WRITE;
      end
      if (w_grant_d) r_mem_wdata <= bus.D_WRITE_DATA;
      if (w_done) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
      end
      // a requester that let go mid-access gets nothing written back
      if (w_done & r_mem_read & ~r_grant & w_i_req) r_i_rdata <= bus.MEM_READ_DATA;
      if (w_done & r_mem_read & r_grant & w_d_req) r_d_rdata <= bus.MEM_READ_DATA;
      if (w_grant_i | ((r_state == IDLE) & ~w_i_req)) r_starve <= '0;
      else if (w_grant_d & (r_starve != CW'(STARVE_LIMIT))) r_starve <= r_starve + CW'(1);
    end
  end
  assign bus.I_BUSYWAIT     = w_i_req & ~((r_state == RESP) & ~r_grant);
  assign bus.D_BUSYWAIT     = w_d_req & ~((r_state == RESP) & r_grant);
  assign bus.I_READ_DATA    = r_i_rdata;
  assign bus.D_READ_DATA    = r_d_rdata;
  assign bus.MEM_READ       = r_mem_read;
  assign bus.MEM_WRITE      = r_mem_write;
  assign bus.MEM_ADDRESS    = r_mem_addr;
  assign bus.MEM_WRITE_DATA = r_mem_wdata;
  assign bus.ARB_STATE      = r_state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  localparam int L = 4;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;
  mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(L)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  int n_checks = 0;
  int n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] f(input int k);
    return (32'(k) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction
  logic [31:0] mem [0:511];
  logic [31:0] ref_mem [0:511];
  logic [31:0] last_i = '0;
  logic [31:0] last_d = '0;
  int n_wait = 0;
  int w_cnt = 0;
  bit rand_wait = 0;
  logic strobe;
  assign strobe = bus.MEM_READ | bus.MEM_WRITE;
  assign bus.MEM_BUSYWAIT = strobe && (w_cnt < n_wait);
  assign bus.MEM_READ_DATA = mem[bus.MEM_ADDRESS[10:2]];
  always @(posedge CLK) begin
    if (!RESET && strobe && !bus.MEM_BUSYWAIT && bus.MEM_WRITE) mem[bus.MEM_ADDRESS[10:2]] = bus.MEM_WRITE_DATA;
    w_cnt <= (!RESET && strobe && bus.MEM_BUSYWAIT) ? w_cnt + 1 : 0;
  end
  always @(posedge CLK) begin
    if (rand_wait) begin
      #1;
      if (!strobe) n_wait = $urandom_range(0, 3);
    end
  end
  byte glog[$];
  int m_cnt = 0;
  int rd_cycles = 0;
  logic p_strobe = 0, p_i = 0, p_d = 0, p_dw = 0, p_rst = 1;
  logic [31:0] p_ia = '0, p_da = '0, p_wd = '0, p_maddr = '0;
  always @(negedge CLK) begin
    logic w_i;
    check("ibw_noreq", 32'(bus.I_BUSYWAIT & ~bus.I_READ), 0);
    check("dbw_noreq", 32'(bus.D_BUSYWAIT & ~(bus.D_READ | bus.D_WRITE)), 0);
    if (bus.MEM_READ) rd_cycles++;
    if (RESET) m_cnt = 0;
    else if (strobe && !p_strobe && !p_rst) begin
      w_i = p_i && (!p_d || m_cnt == L);
      check("gnt_req", 32'(p_i | p_d), 1);
      check("gnt_addr", bus.MEM_ADDRESS, w_i ? p_ia : p_da);
      check("gnt_wr", 32'(bus.MEM_WRITE), 32'(!w_i && p_dw));
      check("gnt_rd", 32'(bus.MEM_READ), 32'(w_i || !p_dw));
      if (!w_i && p_dw) check("gnt_wd", bus.MEM_WRITE_DATA, p_wd);
      m_cnt = w_i ? 0 : p_i ? ((m_cnt < L) ? m_cnt + 1 : L) : 0;
      glog.push_back(w_i ? "I" : "D");
    end else if (strobe && p_strobe) check("addr_hold", bus.MEM_ADDRESS, p_maddr);
    p_strobe = strobe;
    p_rst = RESET;
    p_i = bus.I_READ;
    p_d = bus.D_READ | bus.D_WRITE;
    p_dw = bus.D_WRITE;
    p_ia = bus.I_ADDRESS;
    p_da = bus.D_ADDRESS;
    p_wd = bus.D_WRITE_DATA;
    p_maddr = bus.MEM_ADDRESS;
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic do_i(input logic [31:0] a, output int stalls);
    bus.I_READ = 1;
    bus.I_ADDRESS = a;
    stalls = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (!bus.I_BUSYWAIT) break;
      stalls++;
    end
    check("i_done", 32'(bus.I_BUSYWAIT), 0);
    check("i_rdata", bus.I_READ_DATA, ref_mem[a[10:2]]);
    check("i_hold_d", bus.D_READ_DATA, last_d);
    last_i = ref_mem[a[10:2]];
    tick();
    bus.I_READ = 0;
  endtask
  task automatic do_d(input bit wr, input bit rd_too, input logic [31:0] a, input logic [31:0] d, output int stalls);
    bus.D_WRITE = wr;
    bus.D_READ = wr ? rd_too : 1'b1;
    bus.D_ADDRESS = a;
    bus.D_WRITE_DATA = d;
    stalls = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (!bus.D_BUSYWAIT) break;
      stalls++;
    end
    check("d_done", 32'(bus.D_BUSYWAIT), 0);
    check("d_hold_i", bus.I_READ_DATA, last_i);
    if (wr) begin
      check("d_wr_keeps_rdata", bus.D_READ_DATA, last_d);
      ref_mem[a[10:2]] = d;
    end else begin
      check("d_rdata", bus.D_READ_DATA, ref_mem[a[10:2]]);
      last_d = ref_mem[a[10:2]];
    end
    tick();
    bus.D_READ = 0;
    bus.D_WRITE = 0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int si, sd, n0;
    string exp_order;
    bus.I_READ = 0;
    bus.I_ADDRESS = '0;
    bus.D_READ = 0;
    bus.D_WRITE = 0;
    bus.D_ADDRESS = '0;
    bus.D_WRITE_DATA = '0;
    for (int k = 0; k < 512; k++) begin
      mem[k] = f(k);
      ref_mem[k] = f(k);
    end
    mem[4] = 32'h00300093;
    ref_mem[4] = 32'h00300093;
    RESET = 1;
    bus.I_READ = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_mem_read", 32'(bus.MEM_READ), 0);
    check("rst_mem_write", 32'(bus.MEM_WRITE), 0);
    check("rst_state", 32'(bus.ARB_STATE), 0);
    check("rst_i_rdata", bus.I_READ_DATA, 0);
    check("rst_d_rdata", bus.D_READ_DATA, 0);
    tick();
    RESET = 0;
    bus.I_READ = 0;
    tick();
    rd_cycles = 0;
    do_i(32'h10, si);
    check("lone_stalls", 32'(si), 2);
    check("lone_rd_cycles", 32'(rd_cycles), 1);
    check("lone_data", bus.I_READ_DATA, 32'h00300093);
    n0 = glog.size();
    fork
      do_d(1, 1, 32'h100, 32'hDEADBEEF, sd);
      do_i(32'h14, si);
    join
    check("cont_d_stalls", 32'(sd), 2);
    check("cont_i_stalls", 32'(si), 5);
    check("cont_first", 32'(glog[n0]), 32'("D"));
    check("cont_second", 32'(glog[n0 + 1]), 32'("I"));
    check("cont_wdata", bus.MEM_WRITE_DATA, 32'hDEADBEEF);
    n0 = glog.size();
    exp_order = "DDDDIDD";
    fork
      do_i(32'h18, si);
      for (int k = 0; k < 6; k++) do_d(0, 0, 32'h100 + 32'(4 * k), 0, sd);
    join
    check("starve_count", 32'(glog.size() - n0), 7);
    for (int k = 0; k < 7; k++) check($sformatf("starve_gnt%0d", k), 32'(glog[n0 + k]), 32'(exp_order[k]));
    check("starve_cnt_clr", 32'(dut.r_starve), 0);
    n_wait = 3;
    do_d(0, 0, 32'h20, 0, sd);
    check("wait_stalls", 32'(sd), 5);
    check("wait_addr", bus.MEM_ADDRESS, 32'h20);
    n_wait = 5;
    bus.D_READ = 1;
    bus.D_ADDRESS = 32'h24;
    tick();
    bus.I_READ = 1;
    bus.I_ADDRESS = 32'h28;
    tick();
    RESET = 1;
    bus.D_READ = 0;
    @(negedge CLK);
    @(negedge CLK);
    check("midrst_mem_read", 32'(bus.MEM_READ), 0);
    check("midrst_mem_write", 32'(bus.MEM_WRITE), 0);
    check("midrst_state", 32'(bus.ARB_STATE), 0);
    check("midrst_d_rdata", bus.D_READ_DATA, 0);
    check("midrst_i_rdata", bus.I_READ_DATA, 0);
    last_i = '0;
    last_d = '0;
    n_wait = 0;
    tick();
    RESET = 0;
    do_i(32'h28, si);
    check("midrst_i_stalls", 32'(si), 2);
    rand_wait = 1;
    fork
      for (int k = 0; k < 30; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        do_i({24'h0, 6'($urandom_range(0, 63)), 2'b00}, si);
      end
      for (int k = 0; k < 50; k++) begin
        repeat ($urandom_range(0, 2)) tick();
        do_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h100 + 32'(4 * $urandom_range(0, 63)), $urandom, sd);
      end
    join
    rand_wait = 0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
